// File: rtl/sens_hispi_lane.sv
// sens_hispi_lane
// Single-lane HiSPi Packetized-SP word aligner and sync decoder (12-bit words).
// Finds bit/word alignment from the 0xFFF/0x000/0x000 preamble, decodes the
// SOF/SOL/EOL/EOF code word, strips sync words and emits aligned pixel words.
// Optional feature: define SENS_HISPI_LANE_STATS_EN to enable the saturating
// sync error counter on sync_errs; otherwise sync_errs is tied to zero.
module sens_hispi_lane (
    input  logic        ipclk,
    input  logic        irst_n,
    input  logic [3:0]  din,
    output logic [11:0] dout,
    output logic        dv,
    output logic        sof,
    output logic        sol,
    output logic        eol,
    output logic        eof,
    output logic        locked,
    output logic        in_line,
    output logic [7:0]  sync_errs
);

    // 12 ones followed by 24 zeros, oldest bit in the MSB.
    localparam logic [35:0] PREAMBLE = 36'hFFF_000_000;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_CODE = 2'd1,
        ST_DATA = 2'd2,
        ST_IDLE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Bit history. The newest nibble sits in [3:0]. The preamble window for the
    // highest offset ends at bit 38, so nothing above that is kept.
    logic [38:0] r_hist;
    logic [1:0]  r_off;
    logic [1:0]  r_phase;

    // Two-word delay queue: r_q0 is the youngest entry, r_q1 the oldest.
    logic [11:0] r_q0;
    logic [11:0] r_q1;
    logic [1:0]  r_qv;

    // A valid code has been decoded since the last return to HUNT.
    logic        r_seen;

    logic        w_pre_hit;
    logic [1:0]  w_pre_k;
    logic [11:0] w_word;
    logic        w_wc;
    logic        w_locked_st;
    logic        w_pre_aligned;
    logic        w_code_eval;
    logic        w_push;
    logic        w_dv;
    logic        w_realign;
    logic        w_q_clr;
    logic        w_seen_nxt;
    logic        w_sof;
    logic        w_sol;
    logic        w_eol;
    logic        w_eof;

    // Preamble search over the four bit offsets, lowest offset wins.
    always_comb begin
        w_pre_hit = 1'b0;
        w_pre_k   = 2'd0;
        if (r_hist[35:0] == PREAMBLE) begin
            w_pre_hit = 1'b1;
            w_pre_k   = 2'd0;
        end else if (r_hist[36:1] == PREAMBLE) begin
            w_pre_hit = 1'b1;
            w_pre_k   = 2'd1;
        end else if (r_hist[37:2] == PREAMBLE) begin
            w_pre_hit = 1'b1;
            w_pre_k   = 2'd2;
        end else if (r_hist[38:3] == PREAMBLE) begin
            w_pre_hit = 1'b1;
            w_pre_k   = 2'd3;
        end else begin
            w_pre_hit = 1'b0;
            w_pre_k   = 2'd0;
        end
    end

    // Current 12-bit word at the locked bit offset.
    always_comb begin
        w_word = r_hist[11:0];
        case (r_off)
            2'd0:    w_word = r_hist[11:0];
            2'd1:    w_word = r_hist[12:1];
            2'd2:    w_word = r_hist[13:2];
            2'd3:    w_word = r_hist[14:3];
            default: w_word = r_hist[11:0];
        endcase
    end

    // Phase 2 is the cycle in which a complete word sits at the offset.
    assign w_wc          = (r_phase == 2'd2);
    assign w_locked_st   = (r_state == ST_DATA) || (r_state == ST_IDLE);
    assign w_pre_aligned = w_pre_hit && w_wc && (w_pre_k == r_off);
    assign w_code_eval   = (r_state == ST_CODE) && w_wc;

    // State register.
    always_ff @(posedge ipclk or negedge irst_n) begin
        if (!irst_n) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. All legal codes have bit 11 set; bit 9 separates
    // end-of-line codes (to IDLE) from start-of-line codes (to DATA).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_HUNT: begin
                if (w_pre_hit) begin
                    w_state_nxt = ST_CODE;
                end else begin
                    w_state_nxt = ST_HUNT;
                end
            end
            ST_CODE: begin
                if (!w_wc) begin
                    w_state_nxt = ST_CODE;
                end else if (!w_word[11]) begin
                    w_state_nxt = ST_HUNT;
                end else if (w_word[9]) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_pre_hit) begin
                    w_state_nxt = ST_CODE;
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_IDLE: begin
                if (w_pre_hit) begin
                    w_state_nxt = ST_CODE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_HUNT;
            end
        endcase
    end

    // Output and datapath control decoded from state and the current word.
    always_comb begin
        w_sof      = 1'b0;
        w_sol      = 1'b0;
        w_eol      = 1'b0;
        w_eof      = 1'b0;
        w_push     = 1'b0;
        w_dv       = 1'b0;
        w_realign  = 1'b0;
        w_q_clr    = 1'b0;
        w_seen_nxt = r_seen;

        if (w_code_eval && w_word[11]) begin
            w_sol = !w_word[9];
            w_sof = w_word[10] && !w_word[9];
            w_eol = w_word[9];
            w_eof = w_word[10] && w_word[9];
        end else begin
            w_sol = 1'b0;
            w_sof = 1'b0;
            w_eol = 1'b0;
            w_eof = 1'b0;
        end

        // A preamble in DATA is never queued, so its own words never exit.
        if ((r_state == ST_DATA) && w_wc && !w_pre_hit) begin
            w_push = 1'b1;
            w_dv   = r_qv[1];
        end else begin
            w_push = 1'b0;
            w_dv   = 1'b0;
        end

        if (w_pre_hit && ((r_state == ST_HUNT) || (w_locked_st && !w_pre_aligned))) begin
            w_realign = 1'b1;
        end else begin
            w_realign = 1'b0;
        end

        // Any preamble while locked squashes the queued sync words.
        if ((w_locked_st && w_pre_hit) || (r_state == ST_HUNT) || (w_state_nxt == ST_HUNT)) begin
            w_q_clr = 1'b1;
        end else begin
            w_q_clr = 1'b0;
        end

        if (w_state_nxt == ST_HUNT) begin
            w_seen_nxt = 1'b0;
        end else if (w_code_eval && w_word[11]) begin
            w_seen_nxt = 1'b1;
        end else begin
            w_seen_nxt = r_seen;
        end
    end

    // Bit history, alignment offset, word phase and the lock qualifier.
    always_ff @(posedge ipclk or negedge irst_n) begin
        if (!irst_n) begin
            r_hist  <= 39'd0;
            r_off   <= 2'd0;
            r_phase <= 2'd0;
            r_seen  <= 1'b0;
        end else begin
            r_hist <= {r_hist[34:0], din};
            r_seen <= w_seen_nxt;
            if (w_realign) begin
                r_off   <= w_pre_k;
                r_phase <= 2'd0;
            end else if (r_phase == 2'd2) begin
                r_phase <= 2'd0;
            end else begin
                r_phase <= r_phase + 2'd1;
            end
        end
    end

    // Two-word delay queue holding back words until a preamble is ruled out.
    always_ff @(posedge ipclk or negedge irst_n) begin
        if (!irst_n) begin
            r_q0 <= 12'd0;
            r_q1 <= 12'd0;
            r_qv <= 2'b00;
        end else if (w_q_clr) begin
            r_qv <= 2'b00;
        end else if (w_push) begin
            r_q0 <= w_word;
            r_q1 <= r_q0;
            r_qv <= {r_qv[0], 1'b1};
        end
    end

    // Registered outputs; dout holds its value between strobes.
    always_ff @(posedge ipclk or negedge irst_n) begin
        if (!irst_n) begin
            dout    <= 12'd0;
            dv      <= 1'b0;
            sof     <= 1'b0;
            sol     <= 1'b0;
            eol     <= 1'b0;
            eof     <= 1'b0;
            locked  <= 1'b0;
            in_line <= 1'b0;
        end else begin
            if (w_dv) begin
                dout <= r_q1;
            end
            dv      <= w_dv;
            sof     <= w_sof;
            sol     <= w_sol;
            eol     <= w_eol;
            eof     <= w_eof;
            locked  <= (w_state_nxt != ST_HUNT) && w_seen_nxt;
            in_line <= (w_state_nxt == ST_DATA);
        end
    end

`ifdef SENS_HISPI_LANE_STATS_EN
    logic       w_err;
    logic [7:0] r_sync_errs;

    // Bad codes always count; preambles count only when off-grid while locked.
    assign w_err = (w_code_eval && !w_word[11]) ||
                   (w_locked_st && w_pre_hit && !w_pre_aligned);

    // Saturating sync error counter, cleared only by reset.
    always_ff @(posedge ipclk or negedge irst_n) begin
        if (!irst_n) begin
            r_sync_errs <= 8'd0;
        end else if (w_err && (r_sync_errs != 8'hFF)) begin
            r_sync_errs <= r_sync_errs + 8'd1;
        end
    end

    assign sync_errs = r_sync_errs;
`else
    assign sync_errs = 8'd0;
`endif

endmodule

// File: tb/tb_sens_hispi_lane.sv
// Directed bench for sens_hispi_lane: a bit-level stream builder feeds the
// lane, and queues of expected pixel words and code strobes (with the cycle
// they must appear) are compared against the DUT outputs.
module tb_sens_hispi_lane;

    logic        ipclk = 1'b0;
    logic        irst_n = 1'b0;
    logic [3:0]  din = 4'd0;
    logic [11:0] dout;
    logic        dv;
    logic        sof;
    logic        sol;
    logic        eol;
    logic        eof;
    logic        locked;
    logic        in_line;
    logic [7:0]  sync_errs;

    sens_hispi_lane dut (
        .ipclk     (ipclk),
        .irst_n    (irst_n),
        .din       (din),
        .dout      (dout),
        .dv        (dv),
        .sof       (sof),
        .sol       (sol),
        .eol       (eol),
        .eof       (eof),
        .locked    (locked),
        .in_line   (in_line),
        .sync_errs (sync_errs)
    );

    always #5 ipclk = ~ipclk;

    // kind: 0 plain bit, 1 last bit of a data word, 2 last bit of a code word
    typedef struct {
        bit          b;
        bit          usr;
        int          kind;
        logic [11:0] w;
    } sbit_t;

    typedef struct {
        logic [11:0] w;
        int          t;
    } exp_t;

    sbit_t sb[$];
    exp_t  dq[$];
    exp_t  cq[$];

    int cyc      = 0;
    int checks   = 0;
    int errors   = 0;
    int dv_cnt   = 0;
    int st_cnt   = 0;
    int usr_left = 0;
    int saved_dv = 0;
    int saved_st = 0;

`ifdef SENS_HISPI_LANE_STATS_EN
    localparam logic [7:0] ERR1 = 8'd1;
    localparam logic [7:0] ERR2 = 8'd2;
`else
    localparam logic [7:0] ERR1 = 8'd0;
    localparam logic [7:0] ERR2 = 8'd0;
`endif

    always @(posedge ipclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Push one 12-bit word MSB first; the last bit carries the scoreboard tag.
    task automatic put_word(input logic [11:0] v, input int kind, input logic [3:0] strb);
        for (int i = 11; i >= 0; i--) begin
            sb.push_back('{v[i], 1'b1, (i == 0) ? kind : 0, (kind == 1) ? v : {8'd0, strb}});
            usr_left++;
        end
    endtask

    task automatic put_pad(input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back('{1'b0, 1'b1, 0, 12'd0});
            usr_left++;
        end
    endtask

    task automatic put_pre();
        put_word(12'hFFF, 0, 4'd0);
        put_word(12'h000, 0, 4'd0);
        put_word(12'h000, 0, 4'd0);
    endtask

    task automatic wait_drain(input int extra);
        for (int i = 0; i < 3000 && usr_left > 0; i++) @(posedge ipclk);
        chk("drain_timeout", 32'(usr_left), 32'd0);
        repeat (extra) @(posedge ipclk);
        #1;
    endtask

    // Stream driver: idle filler is added in whole 12-bit words so the word
    // grid never slips unless the stimulus adds pad bits on purpose.
    initial begin : drv
        logic [3:0] nib;
        sbit_t      s;
        forever begin
            @(negedge ipclk);
            if (sb.size() < 4) begin
                for (int i = 0; i < 12; i++) sb.push_back('{1'b0, 1'b0, 0, 12'd0});
            end
            for (int i = 3; i >= 0; i--) begin
                s = sb.pop_front();
                nib[i] = s.b;
                if (s.usr) usr_left--;
                if (s.kind == 1) dq.push_back('{s.w, cyc + 8});
                else if (s.kind == 2) cq.push_back('{s.w, cyc + 2});
            end
            din = nib;
        end
    end

    // Output monitor: every dv and every code strobe must match the scoreboard.
    initial begin : mon
        exp_t       e;
        logic [3:0] st;
        forever begin
            @(negedge ipclk);
            if (dv) begin
                dv_cnt++;
                chk("dv_expected", 32'(dq.size() > 0), 32'd1);
                if (dq.size() > 0) begin
                    e = dq.pop_front();
                    chk("dv_data", 32'(dout), 32'(e.w));
                    chk("dv_time", 32'(cyc), 32'(e.t));
                end
            end
            st = {sof, sol, eol, eof};
            if (st != 4'd0) begin
                st_cnt++;
                chk("strobe_expected", 32'(cq.size() > 0), 32'd1);
                if (cq.size() > 0) begin
                    e = cq.pop_front();
                    chk("strobe_val", 32'(st), 32'(e.w[3:0]));
                    chk("strobe_time", 32'(cyc), 32'(e.t));
                end
            end
        end
    end

    initial begin
        // Reset state
        irst_n = 1'b0;
        repeat (3) @(posedge ipclk);
        #1;
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_dv", 32'(dv), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_in_line", 32'(in_line), 32'd0);
        chk("rst_strobes", 32'({sof, sol, eol, eof}), 32'd0);
        chk("rst_errs", 32'(sync_errs), 32'd0);
        irst_n = 1'b1;

        // Idle stream of zeros
        repeat (100) @(posedge ipclk);
        #1;
        chk("idle_locked", 32'(locked), 32'd0);
        chk("idle_dv", 32'(dv_cnt), 32'd0);
        chk("idle_strobes", 32'(st_cnt), 32'd0);

        // Start of frame at offset 2, then a second line, then end of line
        put_pad(2);
        put_pre();
        put_word(12'hC00, 2, 4'b1100);
        put_word(12'h123, 1, 4'd0);
        put_word(12'h456, 1, 4'd0);
        put_word(12'h789, 1, 4'd0);
        put_pre();
        put_word(12'h800, 2, 4'b0100);
        put_word(12'h0AB, 1, 4'd0);
        put_word(12'hFFF, 1, 4'd0);
        put_word(12'h001, 1, 4'd0);
        put_pre();
        put_word(12'hA00, 2, 4'b0010);
        for (int i = 0; i < 500 && dv_cnt < 1; i++) @(posedge ipclk);
        #1;
        chk("sof_first_dv", 32'(dv_cnt), 32'd1);
        chk("sof_in_line", 32'(in_line), 32'd1);
        chk("sof_locked", 32'(locked), 32'd1);
        wait_drain(12);
        chk("eol_dv_total", 32'(dv_cnt), 32'd6);
        chk("eol_strobes", 32'(st_cnt), 32'd3);
        chk("eol_in_line", 32'(in_line), 32'd0);
        chk("eol_locked", 32'(locked), 32'd1);
        chk("eol_dout_hold", 32'(dout), 32'h001);

        // Bad code after an aligned preamble
        put_pre();
        put_word(12'h400, 0, 4'd0);
        wait_drain(8);
        chk("bad_locked", 32'(locked), 32'd0);
        chk("bad_in_line", 32'(in_line), 32'd0);
        chk("bad_errs", 32'(sync_errs), 32'(ERR1));
        chk("bad_strobes", 32'(st_cnt), 32'd3);

        // Lock at offset 0 into IDLE, then a preamble at offset 1
        put_pad(2);
        put_pre();
        put_word(12'hA00, 2, 4'b0010);
        wait_drain(8);
        chk("k0_locked", 32'(locked), 32'd1);
        chk("k0_errs", 32'(sync_errs), 32'(ERR1));
        put_pad(3);
        put_pre();
        put_word(12'h800, 2, 4'b0100);
        put_word(12'h321, 1, 4'd0);
        put_word(12'h654, 1, 4'd0);
        put_pre();
        put_word(12'hA00, 2, 4'b0010);
        wait_drain(12);
        chk("mis_errs", 32'(sync_errs), 32'(ERR2));
        chk("mis_dv_total", 32'(dv_cnt), 32'd8);
        chk("mis_strobes", 32'(st_cnt), 32'd6);
        chk("mis_locked", 32'(locked), 32'd1);
        chk("mis_in_line", 32'(in_line), 32'd0);

        // Reset in the middle of a line, right while dv is high
        put_pre();
        put_word(12'h800, 2, 4'b0100);
        put_word(12'h111, 1, 4'd0);
        put_word(12'h222, 1, 4'd0);
        put_word(12'h333, 1, 4'd0);
        put_word(12'h444, 1, 4'd0);
        put_word(12'h555, 1, 4'd0);
        put_word(12'h666, 1, 4'd0);
        for (int i = 0; i < 500 && !dv; i++) @(negedge ipclk);
        #2;
        chk("mid_dv_seen", 32'(dv), 32'd1);
        chk("mid_in_line", 32'(in_line), 32'd1);
        irst_n = 1'b0;
        #1;
        chk("arst_dv", 32'(dv), 32'd0);
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_in_line", 32'(in_line), 32'd0);
        chk("arst_errs", 32'(sync_errs), 32'd0);
        sb.delete();
        dq.delete();
        cq.delete();
        usr_left = 0;
        saved_dv = dv_cnt;
        saved_st = st_cnt;
        @(posedge ipclk);
        #1;
        irst_n = 1'b1;
        repeat (40) @(posedge ipclk);
        #1;
        chk("post_rst_dv", 32'(dv_cnt), 32'(saved_dv));
        chk("post_rst_strobes", 32'(st_cnt), 32'(saved_st));
        chk("post_rst_locked", 32'(locked), 32'd0);

        // New frame after reset recovers
        put_pre();
        put_word(12'h800, 2, 4'b0100);
        put_word(12'h5A5, 1, 4'd0);
        put_pre();
        put_word(12'hE00, 2, 4'b0011);
        wait_drain(12);
        chk("rec_dv", 32'(dv_cnt), 32'(saved_dv + 1));
        chk("rec_strobes", 32'(st_cnt), 32'(saved_st + 2));
        chk("rec_dout", 32'(dout), 32'h5A5);
        chk("rec_locked", 32'(locked), 32'd1);
        chk("rec_in_line", 32'(in_line), 32'd0);
        chk("rec_dq_empty", 32'(dq.size()), 32'd0);
        chk("rec_cq_empty", 32'(cq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
